// File: rtl/hpdcache_cmo_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hpdcache_cmo_sched_pkg: CMO operation encoding and scheduler states   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package hpdcache_cmo_sched_pkg;

  typedef struct packed {
    logic is_fence;
    logic is_inval_by_nline;
    logic is_inval_all;
    logic is_flush_by_nline;
    logic is_flush_all;
  } hpdcache_cmoh_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } hpdcache_cmo_sched_fsm_t;

  // A well-formed CMO selects exactly one operation kind.
  function automatic logic cmo_op_is_valid(input hpdcache_cmoh_op_t op);
    return $onehot(op);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpdcache_cmo_sched_rrarb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hpdcache_rrarb: one-hot round-robin arbiter, pointer moves past owner |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hpdcache_rrarb #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  input  logic         update_i,
  input  logic [N-1:0] owner_i
);

  logic [N-1:0] r_rr;
  logic [N-1:0] w_rr_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr <= N'(1);
    end else if (update_i) begin
      r_rr <= w_rr_next;
    end
  end

  always_comb begin
    w_rr_next = '0;
    for (int i = 0; i < N; i++) begin
      w_rr_next[(i + 1) % N] = owner_i[i];
    end
  end

  // First requester at or after the pointer position, searched circularly.
  always_comb begin
    logic w_found;
    gnt_o   = '0;
    w_found = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && r_rr[i] && req_i[(i + off) % N]) begin
          gnt_o[(i + off) % N] = 1'b1;
          w_found              = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpdcache_cmo_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hpdcache_cmo_sched: round-robin scheduler of CMOs onto the handler    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hpdcache_cmo_sched
  import hpdcache_cmo_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter type hpdcache_req_addr_t = logic,
  parameter type hpdcache_req_data_t = logic,
  parameter type hpdcache_req_tid_t  = logic
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  hpdcache_cmoh_op_t  req_op_i    [NREQ],
  input  hpdcache_req_addr_t req_addr_i  [NREQ],
  input  hpdcache_req_data_t req_wdata_i [NREQ],
  input  hpdcache_req_tid_t  req_tid_i   [NREQ],
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic               rsp_error_o,
  output hpdcache_req_tid_t  rsp_tid_o,
  output logic               cmoh_req_valid_o,
  input  logic               cmoh_req_ready_i,
  output hpdcache_cmoh_op_t  cmoh_req_op_o,
  output hpdcache_req_addr_t cmoh_req_addr_o,
  output hpdcache_req_data_t cmoh_req_wdata_o,
  input  logic               cmoh_req_wait_i,
  output logic               busy_o,
  output logic               wait_o
);

  hpdcache_cmo_sched_fsm_t r_state, w_state_d;
  logic [NREQ-1:0]         r_owner;
  hpdcache_cmoh_op_t       r_op;
  hpdcache_req_addr_t      r_addr;
  hpdcache_req_data_t      r_wdata;
  hpdcache_req_tid_t       r_tid;
  logic                    r_err;

  logic [NREQ-1:0]         w_gnt;
  logic                    w_accept;
  hpdcache_cmoh_op_t       w_sel_op;
  hpdcache_req_addr_t      w_sel_addr;
  hpdcache_req_data_t      w_sel_wdata;
  hpdcache_req_tid_t       w_sel_tid;

  hpdcache_rrarb #(.N(NREQ)) u_rrarb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_valid_i),
    .gnt_o    (w_gnt),
    .update_i (r_state == DONE),
    .owner_i  (r_owner)
  );

  assign w_accept = (r_state == IDLE) && (|req_valid_i);

  always_comb begin
    w_sel_op    = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_tid   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_op    = req_op_i[i];
        w_sel_addr  = req_addr_i[i];
        w_sel_wdata = req_wdata_i[i];
        w_sel_tid   = req_tid_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_tid   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_owner <= w_gnt;
        r_op    <= w_sel_op;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_tid   <= w_sel_tid;
        r_err   <= !cmo_op_is_valid(w_sel_op);
      end else if (r_state == DONE) begin
        r_err   <= 1'b0;
      end
    end
  end

  // Malformed ops skip the handler and go straight to the response.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_d = cmo_op_is_valid(w_sel_op) ? ISSUE : DONE;
      ISSUE: if (cmoh_req_ready_i) w_state_d = WAIT;
      WAIT:  if (cmoh_req_ready_i) w_state_d = DONE;
      DONE:  w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o      = (r_state == IDLE) ? w_gnt : '0;
    rsp_valid_o      = (r_state == DONE) ? r_owner : '0;
    rsp_error_o      = (r_state == DONE) && r_err;
    rsp_tid_o        = (r_state == DONE) ? r_tid : '0;
    cmoh_req_valid_o = (r_state == ISSUE);
    cmoh_req_op_o    = r_op;
    cmoh_req_addr_o  = r_addr;
    cmoh_req_wdata_o = r_wdata;
    busy_o           = (r_state != IDLE);
    wait_o           = (r_state == WAIT) && cmoh_req_wait_i;
  end

`ifndef HPDCACHE_ASSERT_OFF
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));
  a_rsp_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(rsp_valid_o));
  a_cmoh_valid_issue: assert property (@(posedge clk_i) disable iff (rst_i)
    cmoh_req_valid_o |-> (r_state == ISSUE));
  a_cmoh_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    cmoh_req_valid_o && !cmoh_req_ready_i |=>
      $stable(cmoh_req_op_o) && $stable(cmoh_req_addr_o) && $stable(cmoh_req_wdata_o));
  for (genvar g = 0; g < NREQ; g++) begin : g_req_hold
    a_valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      req_valid_i[g] && !req_ready_o[g] |=> req_valid_i[g]);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_cmo_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hpdcache_cmo_sched: randomized scoreboard bench, NREQ=4            |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_hpdcache_cmo_sched;
  import hpdcache_cmo_sched_pkg::*;

  localparam int NREQ = 4;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [7:0]  tid_t;

  typedef struct {
    int         owner;
    tid_t       tid;
    bit         err;
    logic [4:0] op;
    addr_t      addr;
    data_t      wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_i;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  hpdcache_cmoh_op_t req_op [NREQ];
  addr_t req_addr [NREQ];
  data_t req_wdata [NREQ];
  tid_t  req_tid [NREQ];
  logic rsp_error, cmoh_valid, cmoh_ready, cmoh_wait, busy, wait_s;
  tid_t rsp_tid;
  hpdcache_cmoh_op_t cmoh_op;
  addr_t cmoh_addr;
  data_t cmoh_wdata;

  always #5 clk = ~clk;

  hpdcache_cmo_sched #(
    .NREQ(NREQ), .hpdcache_req_addr_t(addr_t),
    .hpdcache_req_data_t(data_t), .hpdcache_req_tid_t(tid_t)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_tid_i(req_tid),
    .rsp_valid_o(rsp_valid), .rsp_error_o(rsp_error), .rsp_tid_o(rsp_tid),
    .cmoh_req_valid_o(cmoh_valid), .cmoh_req_ready_i(cmoh_ready),
    .cmoh_req_op_o(cmoh_op), .cmoh_req_addr_o(cmoh_addr), .cmoh_req_wdata_o(cmoh_wdata),
    .cmoh_req_wait_i(cmoh_wait), .busy_o(busy), .wait_o(wait_s)
  );

  int n_chk = 0, n_err = 0, cyc = 0;
  int p_valid = 0, p_keep = 0, p_err = 0, p_stall = 0, busy_max = 0, hbusy = 0;
  logic [NREQ-1:0] acc_mask = '0;
  bit hs = 0;
  txn_t sb[$];
  int gnt_log[$];
  bit m_issue = 0, m_wait = 0, in_wait = 0;
  int m_issue_from = 0, m_wait_from = 0, m_rsp_cyc = -1, m_rr = 0;
  int last_acc = 0, last_rsp = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit op_ok(logic [4:0] v);
    int c = 0;
    for (int b = 0; b < 5; b++) c += int'(v[b]);
    return c == 1;
  endfunction

  function automatic int pick(logic [NREQ-1:0] v, int start);
    for (int k = 0; k < NREQ; k++) if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  function automatic hpdcache_cmoh_op_t rand_op(int perr);
    logic [4:0] v;
    int r = int'($urandom % 100);
    if (r < perr / 2)  v = 5'b0;
    else if (r < perr) v = 5'b00011 << ($urandom % 4);
    else               v = 5'b00001 << ($urandom % 5);
    return hpdcache_cmoh_op_t'(v);
  endfunction

  task automatic new_payload(int i);
    req_op[i]    = rand_op(p_err);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    req_tid[i]   = tid_t'($urandom);
  endtask

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic [4:0] op_bits;
    bit exp_busy, exp_cv, exp_w;
    int w;
    txn_t t;
    cyc++;
    if (rst_i) begin
      sb.delete();
      m_issue = 0; m_wait = 0; m_rsp_cyc = -1; m_rr = 0;
      acc_mask = '0; hs = 0; in_wait = 0;
    end else begin
      exp_busy = (sb.size() != 0);
      chk("busy", 64'(busy), 64'(exp_busy));
      exp_cv = m_issue && (cyc >= m_issue_from);
      chk("cmoh_valid", 64'(cmoh_valid), 64'(exp_cv));
      if (exp_cv && cmoh_valid && sb.size() != 0) begin
        op_bits = cmoh_op;
        chk("cmoh_op", 64'(op_bits), 64'(sb[0].op));
        chk("cmoh_addr", 64'(cmoh_addr), 64'(sb[0].addr));
        chk("cmoh_wdata", 64'(cmoh_wdata), 64'(sb[0].wdata));
        if (cmoh_ready) begin m_issue = 0; m_wait = 1; m_wait_from = cyc + 1; end
      end
      exp_w = m_wait && (cyc >= m_wait_from);
      chk("wait_o", 64'(wait_s), 64'(exp_w && cmoh_wait));
      if (exp_w && cmoh_ready) begin m_wait = 0; m_rsp_cyc = cyc + 1; end
      in_wait = m_wait && (cyc + 1 >= m_wait_from);
      if (sb.size() != 0 && m_rsp_cyc == cyc) begin
        t = sb.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(NREQ'(1) << t.owner));
        chk("rsp_tid", 64'(rsp_tid), 64'(t.tid));
        chk("rsp_error", 64'(rsp_error), 64'(t.err));
        m_rr = (t.owner + 1) % NREQ;
        m_rsp_cyc = -1;
        last_rsp = cyc;
      end else begin
        chk("rsp_valid_quiet", 64'(rsp_valid), 64'(0));
      end
      exp_rdy = '0;
      w = exp_busy ? -1 : pick(req_valid, m_rr);
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_log.push_back(i);
      if (w >= 0) begin
        t.owner = w; t.tid = req_tid[w]; t.op = req_op[w];
        t.addr = req_addr[w]; t.wdata = req_wdata[w]; t.err = !op_ok(t.op);
        sb.push_back(t);
        last_acc = cyc;
        if (t.err) m_rsp_cyc = cyc + 1;
        else begin m_issue = 1; m_issue_from = cyc + 1; end
      end
      acc_mask = req_ready & req_valid;
      hs = cmoh_valid && cmoh_ready;
    end
  end

  // Requesters and a handler that stays busy a random time after each accept.
  task automatic step();
    @(posedge clk); #1;
    if (!rst_i) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && acc_mask[i]) begin
          if (int'($urandom % 100) < p_keep) new_payload(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && int'($urandom % 100) < p_valid) begin
          req_valid[i] = 1'b1;
          new_payload(i);
        end
      end
    end
    if (rst_i) hbusy = 0;
    else if (hs) hbusy = int'($urandom_range(0, busy_max));
    cmoh_ready = (hbusy == 0) && (int'($urandom % 100) >= p_stall);
    if (hbusy > 0) hbusy--;
    cmoh_wait = 1'($urandom % 2);
  endtask

  initial begin
    logic [4:0] op_bits;
    int guard;
    rst_i = 1'b1; req_valid = '0; cmoh_ready = 1'b0; cmoh_wait = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i] = '0; req_addr[i] = '0; req_wdata[i] = '0; req_tid[i] = '0;
    end
    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk); #1;
    op_bits = cmoh_op;
    chk("reset_cmoh_op", 64'(op_bits), 64'(0));
    chk("reset_cmoh_addr", 64'(cmoh_addr), 64'(0));
    chk("reset_rsp_tid", 64'(rsp_tid), 64'(0));
    chk("reset_wait_o", 64'(wait_s), 64'(0));

    // Fence from requester 0, handler always ready: response three cycles after accept.
    step();
    req_valid[0] = 1'b1; req_op[0] = hpdcache_cmoh_op_t'(5'b10000);
    req_tid[0] = 8'd5; req_addr[0] = 32'h1000; req_wdata[0] = 32'hA5A5;
    repeat (8) step();
    chk("fence_latency", 64'(last_rsp - last_acc), 64'(3));

    // Malformed ops: zero and two bits set.
    req_valid[1] = 1'b1; req_op[1] = hpdcache_cmoh_op_t'(5'b00000); req_tid[1] = 8'h11;
    req_valid[2] = 1'b1; req_op[2] = hpdcache_cmoh_op_t'(5'b01010); req_tid[2] = 8'h22;
    repeat (8) step();
    chk("error_latency", 64'(last_rsp - last_acc), 64'(1));

    // Handler refuses in ISSUE for several cycles.
    p_stall = 100;
    req_valid[3] = 1'b1; req_op[3] = hpdcache_cmoh_op_t'(5'b00001); req_addr[3] = 32'hBEEF0;
    repeat (6) step();
    p_stall = 0;
    repeat (6) step();

    // All requesters valid continuously from reset: strict rotation.
    rst_i = 1'b1;
    p_valid = 100; p_keep = 100; p_err = 0; busy_max = 3; p_stall = 20;
    for (int i = 0; i < NREQ; i++) begin req_valid[i] = 1'b1; new_payload(i); end
    step();
    rst_i = 1'b0;
    gnt_log.delete();
    guard = 0;
    while (gnt_log.size() < 8 && guard < 400) begin step(); guard++; end
    chk("fair_count", 64'(gnt_log.size() >= 8), 64'(1));
    for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("grant_order", 64'(gnt_log[k]), 64'(k % NREQ));

    // Random mix of traffic, errors, stalls and handler delays.
    p_valid = 30; p_keep = 50; p_err = 20; busy_max = 6; p_stall = 30;
    repeat (3000) step();

    // Reset while waiting for the handler.
    p_valid = 100; p_keep = 100; p_err = 0; busy_max = 10; p_stall = 0;
    guard = 0;
    while (!in_wait && guard < 200) begin step(); guard++; end
    chk("reach_wait", 64'(in_wait), 64'(1));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    gnt_log.delete();
    repeat (6) step();
    chk("post_reset_grant", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'(0));
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
